// File: rtl/con_pkg.sv
// Shared condition-code definitions for the CON flag unit.
package con_pkg;

  localparam int COND_W = 3;

  localparam logic [COND_W-1:0] COND_ZR = 3'b000; // v == 0
  localparam logic [COND_W-1:0] COND_NZ = 3'b001; // v != 0
  localparam logic [COND_W-1:0] COND_PL = 3'b010; // sign bit clear
  localparam logic [COND_W-1:0] COND_MI = 3'b011; // sign bit set
  localparam logic [COND_W-1:0] COND_GT = 3'b100; // v > 0 signed
  localparam logic [COND_W-1:0] COND_LE = 3'b101; // v <= 0 signed
  localparam logic [COND_W-1:0] COND_AL = 3'b110; // always
  localparam logic [COND_W-1:0] COND_NV = 3'b111; // never

endpackage

// File: rtl/con_eval.sv
// Combinational condition evaluator: (cond, value) -> 1-bit result.
module con_eval
  import con_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [COND_W-1:0] i_cond,
  input  logic [DATA_W-1:0] i_value,
  output logic              o_res
);

  logic w_zero;
  logic w_neg;

  assign w_zero = ~|i_value;
  assign w_neg  = i_value[DATA_W-1];

  // Decode the condition field against zero/sign of the operand.
  always_comb begin
    o_res = 1'b0;
    case (i_cond)
      COND_ZR: o_res = w_zero;
      COND_NZ: o_res = ~w_zero;
      COND_PL: o_res = ~w_neg;
      COND_MI: o_res = w_neg;
      COND_GT: o_res = ~w_neg & ~w_zero;
      COND_LE: o_res = w_neg | w_zero;
      COND_AL: o_res = 1'b1;
      COND_NV: o_res = 1'b0;
      default: o_res = 1'b0;
    endcase
  end

endmodule

// File: rtl/con_unit_p.sv
// CON flag unit: optional input stage, registered flag/valid, saturating
// taken/evaluated counters.
module con_unit_p
  import con_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 0,
  parameter int CNT_W       = 16
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [COND_W-1:0] cond_bits,
  input  logic [DATA_W-1:0] Bus_Data,
  input  logic              CONin,
  input  logic              CONclr,
  input  logic              cnt_clr,
  output logic              CON_Out,
  output logic              CON_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  eval_count
);

  // w_fire marks the edge at which a result is written.
  logic              w_fire;
  logic [COND_W-1:0] w_cond;
  logic [DATA_W-1:0] w_value;
  logic              w_res;

  logic              r_con;
  logic              r_valid;
  logic [CNT_W-1:0]  r_taken;
  logic [CNT_W-1:0]  r_eval;

  if (DATA_W < 2) begin : g_bad_w
    $error("con_unit_p: DATA_W must be >= 2");
  end

  if (PIPE_STAGES == 1) begin : g_pipe
    logic              r_stg_vld;
    logic [COND_W-1:0] r_stg_cond;
    logic [DATA_W-1:0] r_stg_data;

    // Input stage: refills every cycle CONin is high, drains otherwise.
    always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
        r_stg_vld  <= 1'b0;
        r_stg_cond <= '0;
        r_stg_data <= '0;
      end else begin
        r_stg_vld <= CONin;
        if (CONin) begin
          r_stg_cond <= cond_bits;
          r_stg_data <= Bus_Data;
        end
      end
    end

    assign w_fire  = r_stg_vld;
    assign w_cond  = r_stg_cond;
    assign w_value = r_stg_data;
    assign busy    = r_stg_vld;
  end else if (PIPE_STAGES == 0) begin : g_direct
    assign w_fire  = CONin;
    assign w_cond  = cond_bits;
    assign w_value = Bus_Data;
    assign busy    = 1'b0;
  end else begin : g_bad_p
    $error("con_unit_p: PIPE_STAGES must be 0 or 1");
    assign w_fire  = 1'b0;
    assign w_cond  = '0;
    assign w_value = '0;
    assign busy    = 1'b0;
  end

  con_eval #(.DATA_W(DATA_W)) u_eval (
    .i_cond  (w_cond),
    .i_value (w_value),
    .o_res   (w_res)
  );

  // Flag/valid: a result write beats a same-cycle consume.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_con   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_con   <= w_res;
      r_valid <= 1'b1;
    end else if (CONclr) begin
      r_con   <= 1'b0;
      r_valid <= 1'b0;
    end
  end

  // Saturating counters; clear takes priority over an increment.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_taken <= '0;
      r_eval  <= '0;
    end else if (cnt_clr) begin
      r_taken <= '0;
      r_eval  <= '0;
    end else if (w_fire) begin
      if (r_eval != '1) r_eval <= r_eval + CNT_W'(1);
      if (w_res && (r_taken != '1)) r_taken <= r_taken + CNT_W'(1);
    end
  end

  assign CON_Out     = r_con;
  assign CON_valid   = r_valid;
  assign taken_count = r_taken;
  assign eval_count  = r_eval;

endmodule

// File: tb/tb_con_unit_p.sv
// Directed bench: three instances (direct/32b, piped/32b, piped/8b/2b counters).
module tb_con_unit_p;

  logic        Clock;
  logic        Clear;
  logic [2:0]  cond_bits;
  logic [31:0] bus;
  logic [7:0]  bus8;
  logic        CONin, CONclr, cnt_clr;

  logic        o0, v0, b0;
  logic [15:0] t0, e0;
  logic        o1, v1, b1;
  logic [15:0] t1, e1;
  logic        o2, v2, b2;
  logic [1:0]  t2, e2;

  int n_tests = 0;
  int n_fail  = 0;

  assign bus8 = bus[7:0];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  con_unit_p #(.DATA_W(32), .PIPE_STAGES(0), .CNT_W(16)) u0 (
    .Clock(Clock), .Clear(Clear), .cond_bits(cond_bits), .Bus_Data(bus),
    .CONin(CONin), .CONclr(CONclr), .cnt_clr(cnt_clr),
    .CON_Out(o0), .CON_valid(v0), .busy(b0), .taken_count(t0), .eval_count(e0));

  con_unit_p #(.DATA_W(32), .PIPE_STAGES(1), .CNT_W(16)) u1 (
    .Clock(Clock), .Clear(Clear), .cond_bits(cond_bits), .Bus_Data(bus),
    .CONin(CONin), .CONclr(CONclr), .cnt_clr(cnt_clr),
    .CON_Out(o1), .CON_valid(v1), .busy(b1), .taken_count(t1), .eval_count(e1));

  con_unit_p #(.DATA_W(8), .PIPE_STAGES(1), .CNT_W(2)) u2 (
    .Clock(Clock), .Clear(Clear), .cond_bits(cond_bits), .Bus_Data(bus8),
    .CONin(CONin), .CONclr(CONclr), .cnt_clr(cnt_clr),
    .CON_Out(o2), .CON_valid(v2), .busy(b2), .taken_count(t2), .eval_count(e2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge, then settle past it before sampling.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    CONin = 0; CONclr = 0; cnt_clr = 0;
  endtask

  typedef struct {
    logic [2:0]  cond;
    logic [31:0] val;
    logic        exp32;
    logic        exp8;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{3'b000, 32'h0000_0000, 1'b1, 1'b1};
    vecs[1]  = '{3'b001, 32'h0000_0000, 1'b0, 1'b0};
    vecs[2]  = '{3'b011, 32'h8000_0000, 1'b1, 1'b0};
    vecs[3]  = '{3'b100, 32'h8000_0000, 1'b0, 1'b0};
    vecs[4]  = '{3'b101, 32'h8000_0000, 1'b1, 1'b1};
    vecs[5]  = '{3'b100, 32'h0000_0001, 1'b1, 1'b1};
    vecs[6]  = '{3'b010, 32'h0000_0001, 1'b1, 1'b1};
    vecs[7]  = '{3'b110, 32'h1234_5678, 1'b1, 1'b1};
    vecs[8]  = '{3'b111, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{3'b000, 32'h0000_0005, 1'b0, 1'b0};
    vecs[10] = '{3'b001, 32'h8000_0000, 1'b1, 1'b0};
    vecs[11] = '{3'b010, 32'h8000_0000, 1'b0, 1'b1};
    vecs[12] = '{3'b101, 32'h0000_0000, 1'b1, 1'b1};
    vecs[13] = '{3'b100, 32'h0000_0000, 1'b0, 1'b0};
    vecs[14] = '{3'b011, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[15] = '{3'b100, 32'h0000_007F, 1'b1, 1'b1};
    vecs[16] = '{3'b100, 32'h0000_00FF, 1'b1, 1'b0};
    vecs[17] = '{3'b101, 32'h0000_0080, 1'b0, 1'b1};

    Clear = 0; cond_bits = 0; bus = 0;
    idle();
    #2;
    chk("rst_out0", {31'd0, o0}, 0);
    chk("rst_valid0", {31'd0, v0}, 0);
    chk("rst_busy1", {31'd0, b1}, 0);
    chk("rst_eval0", {16'd0, e0}, 0);
    step();
    Clear = 1;
    step();

    // Directed sweep: one CONin, then one idle edge so piped instances land.
    for (int i = 0; i < 18; i++) begin
      CONin = 1; cond_bits = vecs[i].cond; bus = vecs[i].val;
      step();
      chk($sformatf("vec%0d_u0_lat1", i), {31'd0, o0}, {31'd0, vecs[i].exp32});
      chk($sformatf("vec%0d_u1_busy", i), {31'd0, b1}, 1);
      idle(); bus = 32'hDEAD_BEEF;
      step();
      chk($sformatf("vec%0d_u0", i), {31'd0, o0}, {31'd0, vecs[i].exp32});
      chk($sformatf("vec%0d_u0v", i), {31'd0, v0}, 1);
      chk($sformatf("vec%0d_u1", i), {31'd0, o1}, {31'd0, vecs[i].exp32});
      chk($sformatf("vec%0d_u2", i), {31'd0, o2}, {31'd0, vecs[i].exp8});
    end

    // Hold with no CONin/CONclr.
    step(); step();
    chk("hold_u0v", {31'd0, v0}, 1);
    chk("hold_u0", {31'd0, o0}, 0);

    // Back-to-back pipeline: cond 000, bus 0,5,0.
    cnt_clr = 1; step(); idle();
    cond_bits = 3'b000;
    CONin = 1; bus = 0; step();
    chk("bb_busy_c1", {31'd0, b1}, 1);
    chk("bb_u0_c1", {31'd0, o0}, 1);
    bus = 5; step();
    chk("bb_busy_c2", {31'd0, b1}, 1);
    chk("bb_out_c2", {31'd0, o1}, 1);
    chk("bb_u0_c2", {31'd0, o0}, 0);
    bus = 0; step();
    chk("bb_busy_c3", {31'd0, b1}, 1);
    chk("bb_out_c3", {31'd0, o1}, 0);
    idle(); step();
    chk("bb_busy_c4", {31'd0, b1}, 0);
    chk("bb_out_c4", {31'd0, o1}, 1);
    chk("bb_eval_u1", {16'd0, e1}, 3);
    chk("bb_taken_u1", {16'd0, t1}, 2);
    chk("bb_eval_u0", {16'd0, e0}, 3);
    chk("bb_taken_u0", {16'd0, t0}, 2);
    chk("bb_eval_u2sat", {30'd0, e2}, 3);
    chk("bb_taken_u2", {30'd0, t2}, 2);

    // Consume alone, then consume coinciding with a write.
    CONclr = 1; step(); idle();
    chk("clr_u0v", {31'd0, v0}, 0);
    chk("clr_u0", {31'd0, o0}, 0);
    chk("clr_u1v", {31'd0, v1}, 0);
    CONin = 1; CONclr = 1; cond_bits = 3'b110; step(); idle();
    chk("clrw_u0v", {31'd0, v0}, 1);
    chk("clrw_u0", {31'd0, o0}, 1);
    CONclr = 1; step(); idle();
    chk("clrw_u1v", {31'd0, v1}, 1);
    chk("clrw_u1", {31'd0, o1}, 1);
    chk("clrw_u0cleared", {31'd0, v0}, 0);

    // Saturation on 2-bit counters.
    cnt_clr = 1; step(); idle();
    cond_bits = 3'b110; bus = 0;
    for (int k = 0; k < 5; k++) begin CONin = 1; step(); end
    idle(); step();
    chk("sat_eval_u2", {30'd0, e2}, 3);
    chk("sat_taken_u2", {30'd0, t2}, 3);
    chk("nosat_eval_u0", {16'd0, e0}, 5);
    chk("nosat_taken_u0", {16'd0, t0}, 5);
    cnt_clr = 1; CONin = 1; step();
    chk("cclr_eval_u0", {16'd0, e0}, 0);
    chk("cclr_taken_u0", {16'd0, t0}, 0);
    CONin = 0; cnt_clr = 1; step(); idle();
    chk("cclr_eval_u2", {30'd0, e2}, 0);
    chk("cclr_taken_u2", {30'd0, t2}, 0);
    chk("cclr_valid_u2", {31'd0, v2}, 1);

    // Async reset mid-run: outputs drop immediately.
    step();
    Clear = 0; #1;
    chk("arst_u0v", {31'd0, v0}, 0);
    chk("arst_u0", {31'd0, o0}, 0);
    chk("arst_u1v", {31'd0, v1}, 0);
    step(); Clear = 1; step();

    // Reset one cycle after CONin discards the in-flight evaluation.
    CONin = 1; cond_bits = 3'b110; step(); idle();
    chk("inflt_busy", {31'd0, b2}, 1);
    Clear = 0; #1;
    chk("inflt_busy_rst", {31'd0, b2}, 0);
    step(); Clear = 1; step(); step();
    chk("inflt_u2v", {31'd0, v2}, 0);
    chk("inflt_u1v", {31'd0, v1}, 0);
    chk("inflt_u2eval", {30'd0, e2}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/con_unit_p.md
Name: con_unit_p

Overview:
- Parametrised successor to the CPU's branch-condition flip-flop.
- Evaluates an 8-way condition code, taken from the instruction's condition field, against the value on the datapath bus.
- Registers the result as the CON flag with a valid qualifier and an explicit consume/clear.
- Optional input pipeline stage; saturating taken/evaluated performance counters for branch statistics.

Parameters:
- DATA_W, 32: bus/operand width; must be >= 2.
- PIPE_STAGES, 0: 0 = evaluate directly from the bus (latency 1); 1 = register bus and condition first (latency 2). Any other value is an elaboration error.
- CNT_W, 16: width of each performance counter.

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  asynchronous, active-low reset.
- cond_bits  in  3  condition code from the IR condition field.
- Bus_Data  in  DATA_W  operand value on the bus.
- CONin  in  1  sample request; bus and cond_bits are valid this cycle.
- CONclr  in  1  consume: drop CON_valid and CON_Out.
- cnt_clr  in  1  synchronous clear of both counters.
- CON_Out  out  1  registered condition result.
- CON_valid  out  1  CON_Out holds a fresh, unconsumed result.
- busy  out  1  an evaluation is in the pipeline stage (PIPE_STAGES=1 only; else constant 0).
- taken_count  out  CNT_W  evaluations that produced 1.
- eval_count  out  CNT_W  total completed evaluations.

Behaviour:
- Reset (Clear=0, async): CON_Out=0, CON_valid=0, busy=0, both counters 0, pipeline stage empty. Reset mid-evaluation discards it.
- Condition codes (v = operand, signed two's complement):
  - 000 zero: v==0
  - 001 nonzero: v!=0
  - 010 plus: v[MSB]==0
  - 011 minus: v[MSB]==1
  - 100 gt: v>0 signed
  - 101 le: v<=0 signed
  - 110 always: 1
  - 111 never: 0
- PIPE_STAGES=0: at the edge where CONin=1, CON_Out <= eval(cond_bits, Bus_Data) and CON_valid <= 1. Result visible the cycle after CONin.
- PIPE_STAGES=1:
  - At the edge where CONin=1, the stage captures Bus_Data and cond_bits and sets busy.
  - At the next edge, CON_Out and CON_valid are written and busy clears, unless a new CONin refills the stage.
  - Back-to-back CONin is accepted every cycle, throughput 1/cycle, results in order.
- Without CONin or CONclr, CON_Out and CON_valid hold indefinitely.
- CONclr at an edge with no result write: CON_valid <= 0, CON_Out <= 0.
- CONclr coinciding with a result write: the write wins (CON_valid=1, new CON_Out).
- A new result overwrites an unconsumed one. No error flag is raised.
- Counters:
  - On each result write, eval_count increments; taken_count increments if the result is 1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr has priority over an increment in the same cycle.
- Width rules: sign test uses Bus_Data[DATA_W-1]. Zero test covers all DATA_W bits.
- The flag is never combinational from Bus_Data; all outputs are registered.

Decomposition:
- Shared package con_pkg: localparams for the eight condition codes (COND_ZR, COND_NZ, COND_PL, COND_MI, COND_GT, COND_LE, COND_AL, COND_NV) and the 3-bit condition-field width.
- Sub-module con_eval, purely combinational: (cond, value) -> result, parametrised by DATA_W.
- con_unit_p holds the optional stage, flag/valid registers and counters.

Test Plan:
- Reset/sweep, PIPE_STAGES=0, DATA_W=32:
  - Assert Clear=0 mid-run -> all outputs 0 immediately.
  - Release, then CONin with cond=000, bus=0 -> next cycle CON_Out=1, CON_valid=1.
  - cond=001, bus=0 -> CON_Out=0.
- Signed codes:
  - bus=0x80000000: cond 011 -> 1; cond 100 -> 0; cond 101 -> 1.
  - bus=0x00000001: cond 100 -> 1; cond 010 -> 1.
  - cond 110 -> 1 and cond 111 -> 0 for any bus value.
- PIPE_STAGES=1, CONin on 3 consecutive cycles, cond=000, bus=0,5,0:
  - CON_Out = 1,0,1 on cycles 2,3,4.
  - busy high on cycles 1-3.
  - eval_count=3, taken_count=2.
- CONclr alone -> CON_valid=0, CON_Out=0 next cycle. CONclr together with CONin (cond=110) -> CON_valid=1, CON_Out=1.
- CNT_W=2, 5 evaluations with cond=110 -> taken_count and eval_count saturate at 3. Then cnt_clr coinciding with CONin -> both counters 0.
- DATA_W=8, bus=0x7F, cond 100 -> 1. Assert Clear=0 one cycle after CONin with PIPE_STAGES=1 -> busy=0, CON_valid stays 0 after release.
